// File: rtl/axi_ar_arbiter.sv
// rtl/axi_ar_arbiter.sv - round-robin AR channel arbiter with per-ID outstanding read tracking
module axi_ar_arbiter #(
    parameter int MAX_OUTS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic        rlast,
    input  logic        rvalid,
    input  logic        rready,
    output logic [2:0]  inst_outs,
    output logic [2:0]  data_outs
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // last_grant encoding: 0 = instruction port, 1 = data port
    localparam logic       GRANT_INST = 1'b0;
    localparam logic       GRANT_DATA = 1'b1;
    localparam logic [2:0] MAX_CNT    = 3'(MAX_OUTS);

    state_t state;
    logic   last_grant;
    logic   inst_elig;
    logic   data_elig;
    logic   grant_inst;
    logic   grant_data;
    logic   r_retire;
    logic   retire_inst;
    logic   retire_data;
    logic   unused_rid;

    assign arlen   = 8'd0;
    assign arburst = 2'b01;

    // Only rid[0] distinguishes the two requesters; upper ID bits are never issued.
    assign unused_rid = ^rid[3:1];

    // Eligibility and round-robin grant; the port not granted last wins a tie.
    always_comb begin
        inst_elig  = inst_req && (inst_outs < MAX_CNT);
        data_elig  = data_req && (data_outs < MAX_CNT);
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state == IDLE) begin
            if (inst_elig && data_elig) begin
                grant_data = (last_grant == GRANT_INST);
                grant_inst = (last_grant == GRANT_DATA);
            end else begin
                grant_inst = inst_elig;
                grant_data = data_elig;
            end
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // A retire at zero count is a spurious beat and is dropped here.
    assign r_retire    = rvalid && rready && rlast;
    assign retire_inst = r_retire && !rid[0] && (inst_outs != 3'd0);
    assign retire_data = r_retire &&  rid[0] && (data_outs != 3'd0);

    // AR issue FSM: latch the winner on grant, hold until the AR handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_INST;
            arvalid    <= 1'b0;
            araddr     <= 32'd0;
            arid       <= 4'd0;
            arsize     <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        araddr     <= data_addr;
                        arsize     <= {1'b0, data_size};
                        arid       <= 4'd1;
                        arvalid    <= 1'b1;
                        last_grant <= GRANT_DATA;
                        state      <= SEND;
                    end else if (grant_inst) begin
                        araddr     <= inst_addr;
                        arsize     <= {1'b0, inst_size};
                        arid       <= 4'd0;
                        arvalid    <= 1'b1;
                        last_grant <= GRANT_INST;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Instruction in-flight counter: grant increments, retire decrements, both cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_outs <= 3'd0;
        end else if (grant_inst && !retire_inst) begin
            inst_outs <= inst_outs + 3'd1;
        end else if (retire_inst && !grant_inst) begin
            inst_outs <= inst_outs - 3'd1;
        end
    end

    // Data in-flight counter: grant increments, retire decrements, both cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_outs <= 3'd0;
        end else if (grant_data && !retire_data) begin
            data_outs <= data_outs + 3'd1;
        end else if (retire_data && !grant_data) begin
            data_outs <= data_outs - 3'd1;
        end
    end

endmodule
